// File: rtl/mtsp_fetch_pkg.sv
// Shared types and widths for the MTSP instruction fetch stage.
package mtsp_fetch_pkg;

    localparam int PC_W     = 16;
    localparam int UINST_W  = 32;
    localparam int LINE_W   = PC_W - 2;
    localparam int SLOTS    = 4;
    localparam int BUNDLE_W = SLOTS * UINST_W;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        FILL1,
        ISSUE,
        WAIT_PC
    } fetch_state_e;

    // words[SLOTS-1] is slot 0, so a line maps 1:1 onto the memory data bus
    typedef struct packed {
        logic                          valid;
        logic [LINE_W-1:0]             tag;
        logic [SLOTS-1:0][UINST_W-1:0] words;
    } line_entry_t;

endpackage

// File: rtl/mtsp_fetch_line_merge.sv
// Builds the memory-slot-ordered bundle: slots at or after pc[1:0] come from
// the current line, earlier slots from the following line.
module mtsp_fetch_line_merge
    import mtsp_fetch_pkg::*;
(
    input  logic [SLOTS-1:0][UINST_W-1:0] l0_words,
    input  logic [SLOTS-1:0][UINST_W-1:0] l1_words,
    input  logic [1:0]                    pc_lo,
    output logic [SLOTS-1:0][UINST_W-1:0] bundle
);

    always_comb begin
        bundle = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (2'(i) >= pc_lo)
                bundle[SLOTS-1-i] = l0_words[SLOTS-1-i];
            else
                bundle[SLOTS-1-i] = l1_words[SLOTS-1-i];
        end
    end

endmodule

// File: rtl/mtsp_inst_fetch.sv
// Instruction fetch: two-line buffer, single-outstanding memory reads and
// one bundle per ISSUE, fed by the organize stage's next-PC.
//
//   state   | meaning
//   IDLE    | waiting for the first jump
//   FILL0   | get line of cur_pc (promote L1 or read memory)
//   FILL1   | read line+1 into L1 for an unaligned PC
//   ISSUE   | register bundle, pulse nEN low next cycle
//   WAIT_PC | wait for next-PC feedback
module mtsp_inst_fetch
    import mtsp_fetch_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                JMP_nEN,
    input  logic [PC_W-1:0]     JMP_PC,
    input  logic                NEXT_nEN,
    input  logic [PC_W-1:0]     NEXT_PC,
    output logic                IMEM_REQ,
    output logic [LINE_W-1:0]   IMEM_ADDR,
    input  logic                IMEM_ACK,
    input  logic [BUNDLE_W-1:0] IMEM_DATA,
    output logic                nEN,
    output logic [PC_W-1:0]     PC,
    output logic [BUNDLE_W-1:0] UINSTx4
);

    fetch_state_e                  state, state_n;
    logic [PC_W-1:0]               cur_pc;
    line_entry_t                   l0, l1;
    logic                          drop;
    logic [LINE_W-1:0]             drop_addr;
    logic [LINE_W-1:0]             cur_line, nxt_line, fill_addr;
    logic                          jump, l1_hit, l1_next, mem_ok, next_same, fill_req;
    logic [SLOTS-1:0][UINST_W-1:0] merged;

    assign jump     = !JMP_nEN;
    assign cur_line = cur_pc[PC_W-1:2];
    assign nxt_line = cur_line + LINE_W'(1);
    assign l1_hit   = l1.valid && (l1.tag == cur_line);
    assign l1_next  = l1.valid && (l1.tag == nxt_line);
    assign mem_ok   = IMEM_ACK && !drop;
    assign next_same = l0.valid && (NEXT_PC[PC_W-1:2] == l0.tag)
                       && (l1_next || (NEXT_PC[1:0] == 2'b00));

    always_comb begin
        state_n   = state;
        fill_req  = 1'b0;
        fill_addr = cur_line;
        case (state)
            IDLE: ;
            FILL0: begin
                fill_req = !l1_hit;
                if (l1_hit || mem_ok)
                    state_n = (cur_pc[1:0] != 2'b00) ? FILL1 : ISSUE;
            end
            FILL1: begin
                fill_req  = 1'b1;
                fill_addr = nxt_line;
                if (mem_ok)
                    state_n = ISSUE;
            end
            ISSUE:   state_n = WAIT_PC;
            WAIT_PC: if (!NEXT_nEN) state_n = next_same ? ISSUE : FILL0;
            default: state_n = IDLE;
        endcase
        if (jump)
            state_n = FILL0;
    end

    // An abandoned read keeps its address on the bus until acked
    assign IMEM_REQ  = drop || fill_req;
    assign IMEM_ADDR = drop ? drop_addr : fill_addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cur_pc    <= '0;
            l0        <= '0;
            l1        <= '0;
            drop      <= 1'b0;
            drop_addr <= '0;
            nEN       <= 1'b1;
            PC        <= '0;
            UINSTx4   <= '1;
        end else begin
            state <= state_n;
            nEN   <= 1'b1;
            if (drop && IMEM_ACK)
                drop <= 1'b0;
            if (jump) begin
                cur_pc   <= JMP_PC;
                l0.valid <= 1'b0;
                l1.valid <= 1'b0;
                if (IMEM_REQ && !IMEM_ACK) begin
                    drop      <= 1'b1;
                    drop_addr <= IMEM_ADDR;
                end
            end else begin
                case (state)
                    FILL0: begin
                        if (l1_hit) begin
                            l0       <= l1;
                            l1.valid <= 1'b0;
                        end else if (mem_ok) begin
                            l0.valid <= 1'b1;
                            l0.tag   <= cur_line;
                            l0.words <= IMEM_DATA;
                        end
                    end
                    FILL1: begin
                        if (mem_ok) begin
                            l1.valid <= 1'b1;
                            l1.tag   <= nxt_line;
                            l1.words <= IMEM_DATA;
                        end
                    end
                    ISSUE: begin
                        nEN     <= 1'b0;
                        PC      <= cur_pc;
                        UINSTx4 <= merged;
                    end
                    WAIT_PC: begin
                        if (!NEXT_nEN)
                            cur_pc <= NEXT_PC;
                    end
                    default: ;
                endcase
            end
        end
    end

    mtsp_fetch_line_merge u_merge (
        .l0_words (l0.words),
        .l1_words (l1.words),
        .pc_lo    (cur_pc[1:0]),
        .bundle   (merged)
    );

endmodule

// File: tb/tb_mtsp_inst_fetch.sv
// Directed bench for mtsp_inst_fetch with a fixed-latency line memory.
module tb_mtsp_inst_fetch;
    import mtsp_fetch_pkg::*;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                JMP_nEN = 1'b1;
    logic [PC_W-1:0]     JMP_PC = '0;
    logic                NEXT_nEN = 1'b1;
    logic [PC_W-1:0]     NEXT_PC = '0;
    logic                IMEM_REQ;
    logic [LINE_W-1:0]   IMEM_ADDR;
    logic                IMEM_ACK = 1'b0;
    logic [BUNDLE_W-1:0] IMEM_DATA = '0;
    logic                nEN;
    logic [PC_W-1:0]     PC;
    logic [BUNDLE_W-1:0] UINSTx4;

    mtsp_inst_fetch dut (
        .CLK(CLK), .RST(RST), .JMP_nEN(JMP_nEN), .JMP_PC(JMP_PC),
        .NEXT_nEN(NEXT_nEN), .NEXT_PC(NEXT_PC), .IMEM_REQ(IMEM_REQ),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .nEN(nEN), .PC(PC), .UINSTx4(UINSTx4)
    );

    always #5 CLK = ~CLK;

    int total = 0, bad = 0;
    int cyc = 0, b_cnt = 0, b_cyc = 0, req_cyc = 0, stab_err = 0;
    int lat = 2, mcnt = 0, j_cyc = 0, n_cyc = 0;
    logic              prev_req = 1'b0;
    logic [LINE_W-1:0] prev_addr = '0;
    logic [LINE_W-1:0] req_log[$];

    function automatic logic [UINST_W-1:0] w(input logic [LINE_W-1:0] line, input logic [1:0] s);
        return {2'b10, line, 14'h0, s};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model plus bus/bundle monitors, all on the falling edge
    always @(negedge CLK) begin
        if (RST) begin
            IMEM_ACK = 1'b0;
            mcnt     = 0;
            prev_req = 1'b0;
        end else begin
            if (prev_req && !IMEM_ACK && IMEM_REQ && IMEM_ADDR != prev_addr)
                stab_err++;
            prev_req  = IMEM_REQ;
            prev_addr = IMEM_ADDR;
            if (IMEM_REQ) req_cyc++;
            if (nEN === 1'b0) begin
                b_cnt++;
                b_cyc = cyc;
            end
            if (IMEM_ACK) begin
                IMEM_ACK = 1'b0;
            end else if (IMEM_REQ) begin
                mcnt++;
                if (mcnt >= lat) begin
                    IMEM_ACK  = 1'b1;
                    IMEM_DATA = {w(IMEM_ADDR, 2'd0), w(IMEM_ADDR, 2'd1),
                                 w(IMEM_ADDR, 2'd2), w(IMEM_ADDR, 2'd3)};
                    req_log.push_back(IMEM_ADDR);
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic jump(input logic [PC_W-1:0] pc);
        @(negedge CLK);
        JMP_nEN = 1'b0;
        JMP_PC  = pc;
        @(negedge CLK);
        JMP_nEN = 1'b1;
        j_cyc   = cyc;
    endtask

    task automatic next(input logic [PC_W-1:0] pc);
        @(negedge CLK);
        NEXT_nEN = 1'b0;
        NEXT_PC  = pc;
        @(negedge CLK);
        NEXT_nEN = 1'b1;
        n_cyc    = cyc;
    endtask

    task automatic wait_bundle(input int b0, input int budget, input string tag);
        int k = 0;
        while (b_cnt == b0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        total++;
        assert (b_cnt != b0) else begin
            bad++;
            $error("FAIL %s: observed=no bundle expected=bundle within %0d cycles", tag, budget);
        end
        repeat (3) @(negedge CLK);
        chk({tag, "_pulses"}, 128'(b_cnt - b0), 128'(1));
    endtask

    task automatic wait_fill1(input string tag);
        int k = 0;
        while (!(IMEM_REQ === 1'b1 && IMEM_ADDR === LINE_W'(5)) && k < 80) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, 128'(IMEM_REQ === 1'b1 && IMEM_ADDR === LINE_W'(5)), 128'(1));
    endtask

    initial begin
        int b0, q0, r0;

        repeat (3) @(negedge CLK);
        chk("rst_nEN",   128'(nEN), 128'(1));
        chk("rst_pc",    128'(PC), 128'(0));
        chk("rst_uinst", UINSTx4, {128{1'b1}});
        chk("rst_req",   128'(IMEM_REQ), 128'(0));
        chk("rst_addr",  128'(IMEM_ADDR), 128'(0));
        RST = 1'b0;

        b0 = b_cnt; q0 = req_log.size();
        jump(16'h0010);
        wait_bundle(b0, 40, "aligned");
        chk("aligned_pc",   128'(PC), 128'(16'h0010));
        chk("aligned_data", UINSTx4, {w(4, 0), w(4, 1), w(4, 2), w(4, 3)});
        chk("aligned_nreq", 128'(req_log.size() - q0), 128'(1));
        chk("aligned_addr", 128'(req_log[q0]), 128'(4));
        chk("aligned_lat",  128'(b_cyc - j_cyc), 128'(3));

        b0 = b_cnt; q0 = req_log.size();
        jump(16'h0012);
        wait_bundle(b0, 40, "unaligned");
        chk("unaligned_pc",    128'(PC), 128'(16'h0012));
        chk("unaligned_data",  UINSTx4, {w(5, 0), w(5, 1), w(4, 2), w(4, 3)});
        chk("unaligned_nreq",  128'(req_log.size() - q0), 128'(2));
        chk("unaligned_addr0", 128'(req_log[q0]), 128'(4));
        chk("unaligned_addr1", 128'(req_log[q0+1]), 128'(5));

        b0 = b_cnt; r0 = req_cyc;
        next(16'h0013);
        wait_bundle(b0, 10, "sameline");
        chk("sameline_pc",   128'(PC), 128'(16'h0013));
        chk("sameline_data", UINSTx4, {w(5, 0), w(5, 1), w(5, 2), w(4, 3)});
        chk("sameline_req",  128'(req_cyc - r0), 128'(0));
        chk("sameline_lat",  128'(b_cyc - n_cyc), 128'(1));

        b0 = b_cnt; q0 = req_log.size();
        next(16'h0015);
        wait_bundle(b0, 40, "reuse");
        chk("reuse_pc",   128'(PC), 128'(16'h0015));
        chk("reuse_data", UINSTx4, {w(6, 0), w(5, 1), w(5, 2), w(5, 3)});
        chk("reuse_nreq", 128'(req_log.size() - q0), 128'(1));
        chk("reuse_addr", 128'(req_log[q0]), 128'(6));

        b0 = b_cnt; q0 = req_log.size();
        @(negedge CLK);
        JMP_nEN = 1'b0; JMP_PC = 16'h0020;
        NEXT_nEN = 1'b0; NEXT_PC = 16'h0016;
        @(negedge CLK);
        JMP_nEN = 1'b1; NEXT_nEN = 1'b1;
        wait_bundle(b0, 40, "jmpwins");
        chk("jmpwins_pc",   128'(PC), 128'(16'h0020));
        chk("jmpwins_data", UINSTx4, {w(8, 0), w(8, 1), w(8, 2), w(8, 3)});
        chk("jmpwins_nreq", 128'(req_log.size() - q0), 128'(1));
        chk("jmpwins_addr", 128'(req_log[q0]), 128'(8));

        lat = 6;
        b0 = b_cnt; q0 = req_log.size();
        jump(16'h0012);
        wait_fill1("drop_fill1_seen");
        jump(16'h0040);
        wait_bundle(b0, 100, "drop");
        chk("drop_pc",    128'(PC), 128'(16'h0040));
        chk("drop_data",  UINSTx4, {w(16, 0), w(16, 1), w(16, 2), w(16, 3)});
        chk("drop_nreq",  128'(req_log.size() - q0), 128'(3));
        chk("drop_addr1", 128'(req_log[q0+1]), 128'(5));
        chk("drop_addr2", 128'(req_log[q0+2]), 128'(16));
        lat = 2;

        b0 = b_cnt; q0 = req_log.size();
        jump(16'hFFFE);
        wait_bundle(b0, 40, "wrap");
        chk("wrap_pc",    128'(PC), 128'(16'hFFFE));
        chk("wrap_data",  UINSTx4, {w(0, 0), w(0, 1), w(14'h3FFF, 2), w(14'h3FFF, 3)});
        chk("wrap_nreq",  128'(req_log.size() - q0), 128'(2));
        chk("wrap_addr0", 128'(req_log[q0]), 128'(14'h3FFF));
        chk("wrap_addr1", 128'(req_log[q0+1]), 128'(0));

        lat = 6;
        jump(16'h0012);
        wait_fill1("midrst_fill1_seen");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_nEN",   128'(nEN), 128'(1));
        chk("midrst_req",   128'(IMEM_REQ), 128'(0));
        chk("midrst_uinst", UINSTx4, {128{1'b1}});
        chk("midrst_pc",    128'(PC), 128'(0));
        RST = 1'b0;
        lat = 2;
        b0 = b_cnt; r0 = req_cyc;
        repeat (10) @(negedge CLK);
        chk("idle_nobundle", 128'(b_cnt - b0), 128'(0));
        chk("idle_noreq",    128'(req_cyc - r0), 128'(0));

        b0 = b_cnt;
        jump(16'h0010);
        wait_bundle(b0, 40, "restart");
        chk("restart_data", UINSTx4, {w(4, 0), w(4, 1), w(4, 2), w(4, 3)});

        chk("addr_stable", 128'(stab_err), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mtsp_inst_fetch.md
Name: mtsp_inst_fetch

Overview:
Instruction fetch stage that feeds the MTSP instruction-organize stage.
- Keeps two consecutive 4-word instruction lines (current line and line+1) in a small line buffer.
- Fetches lines from instruction memory with a single-outstanding req/ack handshake.
- Presents the bundle in memory-slot order: slot i holds the first word at or after PC whose address[1:0] equals i. The organize stage's rotate by PC[1:0] then yields program order.
- Consumes the organize stage's next-PC feedback and reuses the buffered line+1 when the PC advances into it.

Parameters:
PC_W, 16, PC width in instruction words; line address = PC[PC_W-1:2]
UINST_W, 32, unit instruction width; bundle = 4*UINST_W

Ports:
CLK  in  1  main clock
RST  in  1  synchronous reset, active-high
JMP_nEN  in  1  jump/start request, active low; has priority over NEXT_nEN
JMP_PC  in  PC_W  jump target
NEXT_nEN  in  1  next-PC valid from organize stage, active low
NEXT_PC  in  PC_W  next PC (organize stage PC_OUT)
IMEM_REQ  out  1  line read request
IMEM_ADDR  out  PC_W-2  line address
IMEM_ACK  in  1  read data valid; only meaningful while IMEM_REQ=1
IMEM_DATA  in  4*UINST_W  line data; slot 0 in [4*UINST_W-1 -: UINST_W]
nEN  out  1  bundle valid to organize stage, active low, one-cycle pulse
PC  out  PC_W  bundle PC
UINSTx4  out  4*UINST_W  bundle, slot 0 in MSBs

Behaviour:
- Reset (RST=1 at a clock edge): state IDLE; nEN=1, PC=0, UINSTx4 all ones, IMEM_REQ=0, IMEM_ADDR=0; both buffer entries invalid. The memory is reset by the same RST, so no ack from before reset is honoured.
- Buffer: entries L0 and L1, each holds {valid, line tag, 4 words}. Internal register cur_pc.
- States: IDLE, FILL0, FILL1, ISSUE, WAIT_PC.
- IDLE: wait for JMP_nEN=0.
- Jump (JMP_nEN=0 in any state):
  - cur_pc <= JMP_PC; L0 and L1 invalidated; next state FILL0.
  - Any in-flight request is completed and its data discarded: a drop flag is set; IMEM_REQ stays high until ACK, then a new request is issued.
- FILL0:
  - If L1 is valid and L1.tag == cur_pc line: L0 <= L1 and L1 is invalidated, with no memory access.
  - Otherwise IMEM_REQ=1 with IMEM_ADDR = cur_pc line, held until ACK=1; on ACK, L0 <= data and the tag is set.
  - Then go to FILL1 if cur_pc[1:0]!=0, else ISSUE.
- FILL1: request line+1 (modulo 2^(PC_W-2); wrap from max line to 0); on ACK, fill L1, then ISSUE.
- ISSUE: one cycle.
  - Registered outputs: nEN=0, PC=cur_pc.
  - Slot i of UINSTx4 = (i >= cur_pc[1:0]) ? L0 word i : L1 word i.
  - Next state WAIT_PC.
- WAIT_PC:
  - nEN=1; PC and UINSTx4 hold their last values.
  - On NEXT_nEN=0: cur_pc <= NEXT_PC.
    - Same line as L0: ISSUE directly (1-cycle turnaround); L1 must be valid, or cur_pc[1:0]==0.
    - Otherwise: FILL0.
- NEXT_nEN=0 outside WAIT_PC is ignored.
- Same-cycle JMP_nEN=0 and NEXT_nEN=0: jump wins.
- Throughput: at most one bundle every 2 cycles; same-line reuse costs 0 memory cycles; line+1 reuse costs 1 fill only when the new PC is unaligned.
- Latency: jump to first nEN=0 = 1 + ACK latency (+ second ACK latency if unaligned) + 1 cycle.

Decomposition:
- Shared package mtsp_fetch_pkg: state enum, line entry struct {valid, tag, words[4]}, slot width constants.
- One natural sub-module: mtsp_fetch_line_merge. It is purely combinational: (L0 words, L1 words, pc[1:0]) -> bundle.
- The FSM and buffer stay in mtsp_inst_fetch.

Test Plan:
- Aligned start: JMP_PC=0x0010, memory returns line 4 = {A,B,C,D} after 2 cycles -> a single request, addr 0x004, then nEN=0 with PC=0x0010, UINSTx4={A,B,C,D}.
- Unaligned start: JMP_PC=0x0012, line 4 = {A,B,C,D}, line 5 = {E,F,G,H} -> two requests (0x004, 0x005), then bundle {E,F,C,D}.
- Line reuse: after the previous case, NEXT_PC=0x0015 -> no IMEM_ADDR 0x005 request, L1 promoted, one request for 0x006 = {I,J,K,L}, then bundle {I,F,G,H}.
- Same line: NEXT_PC=0x0013 after PC=0x0012 -> nEN=0 two cycles after NEXT_nEN, no IMEM_REQ.
- Jump during fill: JMP at 0x0040 while a request for 0x005 is pending -> that ack is discarded, next request addr 0x010, bundle contains only line 0x010 data.
- Wrap and reset: JMP_PC=0xFFFE -> requests 0x3FFF then 0x0000. RST mid-FILL1 -> next cycle nEN=1, IMEM_REQ=0, UINSTx4 all ones, state IDLE.
